truth_table_checker: RTL and testbench

Synthesizable, parametrised exhaustive checker for combinational truth-table implementations.
- Sweeps every input vector of width IN_W, drives it to two implementations under test (A and B, e.g. DKNF and DDNF forms) and reads the expected output from a golden table memory.
- After a programmable settle time, compares both implementation outputs against the golden value and accumulates error statistics.
- Replaces bench-only sweep loops so that truth-table blocks of any size can be self-checked in simulation or on hardware.

---
 rtl/truth_table_checker.sv | 206 ++++++++++++++++++++
 tb/tb_truth_table_checker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_checker
// Purpose  : Sweeps every input vector, compares two implementations against
//            a golden table and accumulates mismatch statistics.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_checker #(
    parameter int IN_W        = 13,
    parameter int OUT_W       = 8,
    parameter int SETTLE      = 1,
    parameter int ERR_CNT_W   = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [IN_W-1:0]      stim,
    output logic [IN_W-1:0]      rom_addr,
    input  logic [OUT_W-1:0]     rom_data,
    input  logic [OUT_W-1:0]     dut_a,
    input  logic [OUT_W-1:0]     dut_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 aborted,
    output logic                 err_a,
    output logic                 err_b,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_err_valid,
    output logic [IN_W-1:0]      first_err_idx,
    output logic                 mismatch
);

    localparam int c_SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [IN_W-1:0]        r_stim;
    logic [c_SETTLE_W-1:0]  r_settle;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_aborted;
    logic                   r_err_a;
    logic                   r_err_b;
    logic [ERR_CNT_W-1:0]   r_err_count;
    logic                   r_first_valid;
    logic [IN_W-1:0]        r_first_idx;
    logic                   r_mismatch;

    logic                   w_miss_a;
    logic                   w_miss_b;
    logic                   w_miss;
    logic                   w_last;
    logic                   w_start_sweep;
    logic                   w_check;
    logic                   w_advance;
    logic                   w_finish;
    logic                   w_abort;

    assign w_miss_a = (dut_a != rom_data);
    assign w_miss_b = (dut_b != rom_data);
    assign w_miss   = w_miss_a | w_miss_b;
    // Sweep ends on the final vector, or early on the first failure when enabled.
    assign w_last   = (r_stim == {IN_W{1'b1}}) || (STOP_ON_ERR && w_miss);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_start_sweep = 1'b0;
        w_check       = 1'b0;
        w_advance     = 1'b0;
        w_finish      = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next  = S_APPLY;
                    w_start_sweep = 1'b1;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else if (r_settle == c_SETTLE_LAST) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_check = 1'b1;
                    if (w_last) begin
                        w_state_next = S_DONE;
                        w_finish     = 1'b1;
                    end else begin
                        w_state_next = S_APPLY;
                        w_advance    = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim        <= '0;
            r_settle      <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_aborted     <= 1'b0;
            r_err_a       <= 1'b0;
            r_err_b       <= 1'b0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
            r_mismatch    <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;

            if (w_start_sweep) begin
                r_stim        <= '0;
                r_settle      <= '0;
                r_done        <= 1'b0;
                r_pass        <= 1'b0;
                r_aborted     <= 1'b0;
                r_err_a       <= 1'b0;
                r_err_b       <= 1'b0;
                r_err_count   <= '0;
                r_first_valid <= 1'b0;
                r_first_idx   <= '0;
            end

            // Settle counter wraps to zero as it hands over to CHECK.
            if (r_state == S_APPLY && !abort) begin
                if (r_settle == c_SETTLE_LAST) begin
                    r_settle <= '0;
                end else begin
                    r_settle <= r_settle + 1'b1;
                end
            end

            if (w_abort) begin
                r_aborted <= 1'b1;
            end

            if (w_check) begin
                if (w_miss) begin
                    r_mismatch <= 1'b1;
                    r_err_a    <= r_err_a | w_miss_a;
                    r_err_b    <= r_err_b | w_miss_b;
                    if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                    if (!r_first_valid) begin
                        r_first_valid <= 1'b1;
                        r_first_idx   <= r_stim;
                    end
                end
                if (w_finish) begin
                    r_done <= 1'b1;
                    r_pass <= ~(r_err_a | r_err_b | w_miss);
                end
                if (w_advance) begin
                    r_stim <= r_stim + 1'b1;
                end
            end
        end
    end

    assign stim            = r_stim;
    assign rom_addr        = r_stim;
    assign busy            = (r_state == S_APPLY) || (r_state == S_CHECK);
    assign done            = r_done;
    assign pass            = r_pass;
    assign aborted         = r_aborted;
    assign err_a           = r_err_a;
    assign err_b           = r_err_b;
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_valid;
    assign first_err_idx   = r_first_idx;
    assign mismatch        = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_checker
// Purpose  : Directed bench for truth_table_checker with a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 2;
    localparam int SETTLE = 1;
    localparam int NVEC   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] gold [0:7] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd0, 2'd3};
    logic [7:0] fault_a = 8'h00;
    logic [7:0] fault_b = 8'h00;

    // Instance 0: ERR_CNT_W=2, full sweep
    logic             start0 = 1'b0, abort0 = 1'b0;
    logic [IN_W-1:0]  stim0, addr0, fidx0;
    logic [OUT_W-1:0] rom0, a0, b0;
    logic             busy0, done0, pass0, abt0, ea0, eb0, fv0, mm0;
    logic [1:0]       cnt0;

    // Instance 1: STOP_ON_ERR=1
    logic             start1 = 1'b0;
    logic [IN_W-1:0]  stim1, addr1, fidx1;
    logic [OUT_W-1:0] rom1, a1, b1;
    logic             busy1, done1, pass1, abt1, ea1, eb1, fv1, mm1;
    logic [15:0]      cnt1;

    assign a0 = gold[stim0] ^ {1'b0, fault_a[stim0]};
    assign b0 = gold[stim0] ^ {1'b0, fault_b[stim0]};
    assign a1 = gold[stim1] ^ {1'b0, fault_a[stim1]};
    assign b1 = gold[stim1] ^ {1'b0, fault_b[stim1]};

    always @(posedge clk) begin
        rom0 <= gold[addr0];
        rom1 <= gold[addr1];
    end

    truth_table_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE),
                          .ERR_CNT_W(2), .STOP_ON_ERR(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .stim(stim0), .rom_addr(addr0), .rom_data(rom0),
        .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .aborted(abt0), .err_a(ea0), .err_b(eb0), .err_count(cnt0),
        .first_err_valid(fv0), .first_err_idx(fidx0), .mismatch(mm0)
    );

    truth_table_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE),
                          .ERR_CNT_W(16), .STOP_ON_ERR(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .stim(stim1), .rom_addr(addr1), .rom_data(rom1),
        .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .aborted(abt1), .err_a(ea1), .err_b(eb1), .err_count(cnt1),
        .first_err_valid(fv1), .first_err_idx(fidx1), .mismatch(mm1)
    );

    // Model of instance 0: elapsed cycles since start give vector and phase.
    bit        m_active = 1'b0;
    int        m_t = 0;
    int        m_vec = 0;
    logic [2:0] e_stim = '0, e_fidx = '0;
    bit        e_done = 0, e_pass = 0, e_abt = 0, e_ea = 0, e_eb = 0, e_fv = 0, e_mm = 0;
    int        e_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_t = 0; e_stim = '0; e_fidx = '0;
            e_done = 0; e_pass = 0; e_abt = 0; e_ea = 0; e_eb = 0;
            e_fv = 0; e_mm = 0; e_cnt = 0;
        end else begin
            e_mm = 0;
            if (m_active) begin
                m_vec = m_t / (SETTLE + 1);
                if (abort0) begin
                    m_active = 0;
                    e_abt    = 1;
                end else if (m_t % (SETTLE + 1) == SETTLE) begin
                    if (fault_a[m_vec] || fault_b[m_vec]) begin
                        e_mm = 1;
                        if (fault_a[m_vec]) e_ea = 1;
                        if (fault_b[m_vec]) e_eb = 1;
                        if (e_cnt < 3) e_cnt = e_cnt + 1;
                        if (!e_fv) begin
                            e_fv   = 1;
                            e_fidx = 3'(m_vec);
                        end
                    end
                    if (m_vec == NVEC - 1) begin
                        m_active = 0;
                        e_done   = 1;
                        e_pass   = !(e_ea || e_eb);
                    end else begin
                        m_t    = m_t + 1;
                        e_stim = 3'(m_t / (SETTLE + 1));
                    end
                end else begin
                    m_t = m_t + 1;
                end
            end else if (start0) begin
                m_active = 1; m_t = 0; e_stim = '0; e_fidx = '0;
                e_done = 0; e_pass = 0; e_abt = 0; e_ea = 0; e_eb = 0;
                e_fv = 0; e_cnt = 0;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m.stim",      32'(stim0),  32'(e_stim));
        chk("m.rom_addr",  32'(addr0),  32'(e_stim));
        chk("m.busy",      32'(busy0),  32'(m_active));
        chk("m.done",      32'(done0),  32'(e_done));
        chk("m.pass",      32'(pass0),  32'(e_pass));
        chk("m.aborted",   32'(abt0),   32'(e_abt));
        chk("m.err_a",     32'(ea0),    32'(e_ea));
        chk("m.err_b",     32'(eb0),    32'(e_eb));
        chk("m.err_count", 32'(cnt0),   32'(e_cnt));
        chk("m.first_v",   32'(fv0),    32'(e_fv));
        chk("m.first_idx", 32'(fidx0),  32'(e_fidx));
        chk("m.mismatch",  32'(mm0),    32'(e_mm));
        if (mm0 === 1'b1) pulses = pulses + 1;
    endtask

    // One cycle: model compare at negedge, return 1 time unit after posedge.
    task automatic step();
        @(negedge clk);
        if (chk_en) cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep0();
        int n;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        n = 0;
        while (done0 !== 1'b1 && n < 40) begin
            step();
            n = n + 1;
        end
        chk("sweep_timeout", 32'(done0), 32'd1);
    endtask

    initial begin
        int p0;
        @(posedge clk);
        #1;
        chk_en = 1;
        step();
        // Reset state
        chk("rst.stim", 32'(stim0), 32'd0);
        chk("rst.busy", 32'(busy0), 32'd0);
        chk("rst.done", 32'(done0), 32'd0);
        chk("rst.cnt",  32'(cnt0),  32'd0);
        rst = 1'b0;
        step();

        // 1: clean sweep, stim holds each vector for two cycles
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            chk("s1.stim", 32'(stim0), 32'(i / 2));
            chk("s1.busy", 32'(busy0), 32'd1);
        end
        chk("s1.done_early", 32'(done0), 32'd0);
        step();
        chk("s1.done",  32'(done0), 32'd1);
        chk("s1.pass",  32'(pass0), 32'd1);
        chk("s1.cnt",   32'(cnt0),  32'd0);
        chk("s1.fv",    32'(fv0),   32'd0);
        chk("s1.busy0", 32'(busy0), 32'd0);
        step();

        // 2: B wrong at vector 5 only
        fault_b = 8'b0010_0000;
        p0 = pulses;
        run_sweep0();
        step();
        chk("s2.err_b",  32'(eb0),   32'd1);
        chk("s2.err_a",  32'(ea0),   32'd0);
        chk("s2.cnt",    32'(cnt0),  32'd1);
        chk("s2.fidx",   32'(fidx0), 32'd5);
        chk("s2.pass",   32'(pass0), 32'd0);
        chk("s2.pulses", 32'(pulses - p0), 32'd1);
        fault_b = 8'h00;

        // 3: everything wrong, counter saturates at 3
        fault_a = 8'hFF;
        fault_b = 8'hFF;
        run_sweep0();
        step();
        chk("s3.cnt",   32'(cnt0),  32'd3);
        chk("s3.fidx",  32'(fidx0), 32'd0);
        chk("s3.err_a", 32'(ea0),   32'd1);
        chk("s3.err_b", 32'(eb0),   32'd1);
        chk("s3.pass",  32'(pass0), 32'd0);
        fault_a = 8'h00;
        fault_b = 8'h00;

        // 4: STOP_ON_ERR instance, A wrong at vector 2
        fault_a = 8'b0000_0100;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("s4.busy", 32'(busy1), 32'd1);
        repeat (5) step();
        chk("s4.done_early", 32'(done1), 32'd0);
        step();
        chk("s4.done", 32'(done1), 32'd1);
        chk("s4.stim", 32'(stim1), 32'd2);
        chk("s4.pass", 32'(pass1), 32'd0);
        chk("s4.cnt",  32'(cnt1),  32'd1);
        chk("s4.busy0",32'(busy1), 32'd0);

        // 5: abort in CHECK of vector 4 discards that compare
        fault_a = 8'b0001_0000;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (9) step();
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk("s5.busy",  32'(busy0), 32'd0);
        chk("s5.abt",   32'(abt0),  32'd1);
        chk("s5.done",  32'(done0), 32'd0);
        chk("s5.err_a", 32'(ea0),   32'd0);
        chk("s5.mm",    32'(mm0),   32'd0);
        step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("s5.restart_abt",  32'(abt0),  32'd0);
        chk("s5.restart_stim", 32'(stim0), 32'd0);
        chk("s5.restart_busy", 32'(busy0), 32'd1);
        while (done0 !== 1'b1 && p0 < 100) begin
            step();
            p0 = p0 + 1;
        end
        chk("s5.fidx", 32'(fidx0), 32'd4);
        chk("s5.cnt",  32'(cnt0),  32'd1);
        fault_a = 8'h00;
        step();

        // 6: start while busy is ignored; rst mid-sweep clears everything
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (4) step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (10) step();
        chk("s6.done_early", 32'(done0), 32'd0);
        chk("s6.stim",       32'(stim0), 32'd7);
        step();
        chk("s6.done", 32'(done0), 32'd1);
        chk("s6.pass", 32'(pass0), 32'd1);
        fault_b = 8'b0000_0001;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6.rst_stim", 32'(stim0), 32'd0);
        chk("s6.rst_busy", 32'(busy0), 32'd0);
        chk("s6.rst_errb", 32'(eb0),   32'd0);
        chk("s6.rst_cnt",  32'(cnt0),  32'd0);
        chk("s6.rst_fv",   32'(fv0),   32'd0);
        chk("s6.rst_done1",32'(done1), 32'd0);
        fault_b = 8'h00;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
